// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive-side byte FIFO, status counters and config handshake
package uart_rx_ctrl_pkg;
    typedef enum logic [1:0] {
        STOP_BITS_1   = 2'd0,
        STOP_BITS_1P5 = 2'd1,
        STOP_BITS_2   = 2'd2
    } stop_bits_t;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;
endpackage

module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_num_data_bits,
    input  stop_bits_t cfg_stop_bits,
    input  parity_t    cfg_parity,
    input  logic [3:0] cfg_clk_ratio,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [3:0] num_data_bits,
    output stop_bits_t stop_bits,
    output parity_t    parity,
    output logic [3:0] rx_tx_clk_ratio,
    input  logic       rx_busy,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    output logic       rx_full,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_error,
    input  logic       cnt_clr,
    output logic [7:0] overrun_cnt,
    output logic [7:0] parity_err_cnt
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    logic          rx_done_q;
    logic          capture;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, overrun;

    state_t        state, state_next;
    logic          load_shadow, apply, err_set, cfg_ok;
    logic [3:0]    sh_num_data_bits, sh_clk_ratio;
    stop_bits_t    sh_stop_bits;
    parity_t       sh_parity;

    // rx_done is a level held for several cycles; only its rising edge is a byte
    assign capture   = rx_done & ~rx_done_q;
    assign rx_full   = (count == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = capture & (~rx_full | pop);
    assign overrun   = capture & rx_full & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'd0;
    assign out_error = out_valid ? mem[rd_ptr][8]   : 1'b0;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {rx_error, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            rx_done_q <= rx_done;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            overrun_cnt    <= 8'd0;
            parity_err_cnt <= 8'd0;
        end else begin
            if (overrun && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            if (capture && rx_error && parity_err_cnt != 8'hFF)
                parity_err_cnt <= parity_err_cnt + 8'd1;
        end
    end

    assign cfg_ok = (cfg_num_data_bits >= 4'd5) && (cfg_num_data_bits <= 4'd8)
                    && (cfg_clk_ratio >= 4'd2);

    always_comb begin
        state_next  = state;
        cfg_ready   = 1'b0;
        load_shadow = 1'b0;
        apply       = 1'b0;
        err_set     = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_ok) begin
                        load_shadow = 1'b1;
                        state_next  = S_PENDING;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            S_PENDING: begin
                // a capture edge marks a frame boundary still in flight; wait it out
                if (!rx_busy && !capture) begin
                    apply      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cfg_done         <= 1'b0;
            cfg_err          <= 1'b0;
            sh_num_data_bits <= 4'd8;
            sh_stop_bits     <= STOP_BITS_1;
            sh_parity        <= PARITY_NONE;
            sh_clk_ratio     <= 4'd8;
            num_data_bits    <= 4'd8;
            stop_bits        <= STOP_BITS_1;
            parity           <= PARITY_NONE;
            rx_tx_clk_ratio  <= 4'd8;
        end else begin
            state    <= state_next;
            cfg_done <= apply;
            cfg_err  <= err_set;
            if (load_shadow) begin
                sh_num_data_bits <= cfg_num_data_bits;
                sh_stop_bits     <= cfg_stop_bits;
                sh_parity        <= cfg_parity;
                sh_clk_ratio     <= cfg_clk_ratio;
            end
            if (apply) begin
                num_data_bits   <= sh_num_data_bits;
                stop_bits       <= sh_stop_bits;
                parity          <= sh_parity;
                rx_tx_clk_ratio <= sh_clk_ratio;
            end
        end
    end
endmodule
